// File: rtl/mp_adder_driver_pkg.sv
// Shared defaults, FSM state encoding and counter sizing for the multi-precision adder driver.
// TIMEOUT_CYC_DEF exists only when MP_ADDER_DRV_TIMEOUT_EN is defined.
package mp_adder_driver_pkg;

    localparam int OP_W_DEF      = 513;
    localparam int DONE_MASK_DEF = 1;
`ifdef MP_ADDER_DRV_TIMEOUT_EN
    localparam int TIMEOUT_CYC_DEF = 1024;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } drv_state_e;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mp_cycle_counter.sv
// Saturating up-counter with synchronous clear; o_tc is high once the count has reached LIMIT.
// Clear takes effect on the next edge; no handshake, counts whenever i_en is high.
module mp_cycle_counter
    import mp_adder_driver_pkg::*;
#(
    parameter int LIMIT = 1,
    parameter int W     = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [W-1:0] r_cnt;
    logic         w_at_lim;

    assign w_at_lim = (r_cnt == W'(LIMIT));
    assign o_tc     = w_at_lim;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_lim) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/mp_adder_driver.sv
// One-op-at-a-time initiator for the add/sub unit: start pulse one cycle after accept, response one cycle after a valid done.
// cmd_ready is low from accept until the response handshake; MP_ADDER_DRV_TIMEOUT_EN adds a watchdog on the wait for done.
module mp_adder_driver
    import mp_adder_driver_pkg::*;
#(
    parameter int OP_W      = OP_W_DEF,
    parameter int RES_W     = OP_W + 1,
    parameter int DONE_MASK = DONE_MASK_DEF
`ifdef MP_ADDER_DRV_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sub,
    input  logic [OP_W-1:0]  cmd_a,
    input  logic [OP_W-1:0]  cmd_b,
    output logic             add_start,
    output logic             add_subtract,
    output logic [OP_W-1:0]  add_in_a,
    output logic [OP_W-1:0]  add_in_b,
    input  logic [RES_W-1:0] add_result,
    input  logic             add_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic             rsp_timeout
);

    drv_state_e       r_state;
    logic             r_cmd_rdy;
    logic             r_start;
    logic             r_sub;
    logic [OP_W-1:0]  r_a;
    logic [OP_W-1:0]  r_b;
    logic             r_rsp_vld;
    logic [RES_W-1:0] r_res;

    logic w_accept;
    logic w_cnt_en;
    logic w_mask_ok;
    logic w_done_ok;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_cnt_en  = (r_state == S_START) || (r_state == S_WAIT);
    assign w_done_ok = (r_state == S_WAIT) && add_done && w_mask_ok;

    // Counts from the START cycle (value 0 there), so the first WAIT cycle sees 1.
    mp_cycle_counter #(.LIMIT(DONE_MASK)) u_mask_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_accept),
        .i_en  (w_cnt_en),
        .o_tc  (w_mask_ok)
    );

`ifdef MP_ADDER_DRV_TIMEOUT_EN
    logic r_to;
    logic w_timeout;

    mp_cycle_counter #(.LIMIT(TIMEOUT_CYC)) u_wdog_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_accept),
        .i_en  (w_cnt_en),
        .o_tc  (w_timeout)
    );

    assign rsp_timeout = r_to;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cmd_rdy <= 1'b1;
            r_start   <= 1'b0;
            r_sub     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_rsp_vld <= 1'b0;
            r_res     <= '0;
`ifdef MP_ADDER_DRV_TIMEOUT_EN
            r_to      <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a       <= cmd_a;
                        r_b       <= cmd_b;
                        r_sub     <= cmd_sub;
                        r_start   <= 1'b1;
                        r_cmd_rdy <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_ok) begin
                        r_res     <= add_result;
                        r_rsp_vld <= 1'b1;
                        r_state   <= S_RESP;
`ifdef MP_ADDER_DRV_TIMEOUT_EN
                        r_to      <= 1'b0;
`endif
                    end
`ifdef MP_ADDER_DRV_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_res     <= '0;
                        r_to      <= 1'b1;
                        r_rsp_vld <= 1'b1;
                        r_state   <= S_RESP;
                    end
`endif
                end
                S_RESP: begin
                    // cmd_ready comes back a cycle after the handshake, never combinationally.
                    if (rsp_ready) begin
                        r_rsp_vld <= 1'b0;
                        r_cmd_rdy <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_rdy;
    assign add_start    = r_start;
    assign add_subtract = r_sub;
    assign add_in_a     = r_a;
    assign add_in_b     = r_b;
    assign rsp_valid    = r_rsp_vld;
    assign rsp_result   = r_res;

endmodule

// File: tb/tb_mp_adder_driver.sv
// Bench for mp_adder_driver: behavioural adder, cycle-level expectation model and per-cycle compare.
// Define MP_ADDER_DRV_TIMEOUT_EN to also exercise the watchdog.
module tb_mp_adder_driver;

    localparam int OP_W  = 513;
    localparam int RES_W = 514;
    localparam int TB_TO = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_sub;
    logic [OP_W-1:0]  cmd_a;
    logic [OP_W-1:0]  cmd_b;
    logic             add_start;
    logic             add_subtract;
    logic [OP_W-1:0]  add_in_a;
    logic [OP_W-1:0]  add_in_b;
    logic [RES_W-1:0] add_result;
    logic             add_done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int n_rsp  = 0;

    int adder_lat;
    bit ad_never;
    bit late_kick;

    always #5 clk = ~clk;

    mp_adder_driver #(
`ifdef MP_ADDER_DRV_TIMEOUT_EN
        .TIMEOUT_CYC (TB_TO),
`endif
        .OP_W        (OP_W),
        .DONE_MASK   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_sub      (cmd_sub),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_timeout  (rsp_timeout)
    );

    function automatic logic [RES_W-1:0] arith(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                               input logic s);
        return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    function automatic logic [OP_W-1:0] rnd_op();
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom();
        case ($urandom_range(0, 7))
            0:       t = '1;
            1:       t = '0;
            default: ;
        endcase
        return t[OP_W-1:0];
    endfunction

    task automatic check(input string nm, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Expectation model: cycles counted from the accepting edge; response due at latency+2.
    logic             m_busy  = 1'b0;
    int               m_cyc   = 0;
    int               m_rdy   = 0;
    int               m_lat   = 1;
    bit               m_never = 1'b0;
    logic [RES_W-1:0] m_exp   = '0;
    logic             m_to    = 1'b0;
    logic [OP_W-1:0]  m_a     = '0;
    logic [OP_W-1:0]  m_b     = '0;
    logic             m_sub   = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cyc  <= 0;
            m_rdy  <= 0;
            m_exp  <= '0;
            m_to   <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
            m_sub  <= 1'b0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy  <= 1'b1;
                m_cyc   <= 1;
                m_a     <= cmd_a;
                m_b     <= cmd_b;
                m_sub   <= cmd_sub;
                m_lat   <= adder_lat;
                m_never <= ad_never;
                if (ad_never) begin
                    m_rdy <= TB_TO + 2;
                    m_exp <= '0;
                    m_to  <= 1'b1;
                end else begin
                    m_rdy <= adder_lat + 2;
                    m_exp <= arith(cmd_a, cmd_b, cmd_sub);
                    m_to  <= 1'b0;
                end
            end
        end else begin
            if (m_cyc >= m_rdy && rsp_ready) m_busy <= 1'b0;
            m_cyc <= m_cyc + 1;
        end
    end

    // Behavioural adder: done visible latency cycles after the start cycle, held until the next start.
    logic             ad_done = 1'b0;
    logic [RES_W-1:0] ad_res  = '0;
    int               ad_cnt  = 0;
    bit               ad_run  = 1'b0;

    always @(posedge clk) begin
        if (add_start) begin
            ad_run <= !m_never && (m_lat > 1);
            ad_cnt <= m_lat - 1;
            if (!m_never && m_lat == 1) begin
                ad_done <= 1'b1;
                ad_res  <= arith(add_in_a, add_in_b, add_subtract);
            end else begin
                ad_done <= 1'b0;
            end
        end else if (late_kick) begin
            ad_done <= 1'b1;
            ad_res  <= 514'h123;
        end else if (ad_run) begin
            if (ad_cnt <= 1) begin
                ad_done <= 1'b1;
                ad_res  <= arith(add_in_a, add_in_b, add_subtract);
                ad_run  <= 1'b0;
            end else begin
                ad_cnt <= ad_cnt - 1;
            end
        end
    end

    assign add_done   = ad_done;
    assign add_result = ad_res;

    always @(negedge clk) begin
        check("cmd_ready", cmd_ready, !m_busy);
        check("add_start", add_start, m_busy && (m_cyc == 1));
        check("rsp_valid", rsp_valid, m_busy && (m_cyc >= m_rdy));
        check("add_in_a", add_in_a, m_a);
        check("add_in_b", add_in_b, m_b);
        check("add_subtract", add_subtract, m_sub);
        if (m_busy && m_cyc >= m_rdy) begin
            check("rsp_result", rsp_result, m_exp);
            check("rsp_timeout", rsp_timeout, m_to);
        end
        if (!reset && rsp_valid && rsp_ready) n_rsp++;
    end

    task automatic issue(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic s, input int lat);
        int w;
        adder_lat = lat;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sub   = s;
        cmd_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("issue_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int hold, output logic [RES_W-1:0] res, output logic to,
                           output int cyc, output int starts);
        logic [RES_W-1:0] r0;
        cyc       = 1;
        starts    = 0;
        rsp_ready = (hold == 0);
        @(negedge clk);
        while (!rsp_valid && cyc < 200) begin
            if (add_start) starts++;
            cyc++;
            @(negedge clk);
        end
        check("rsp_valid_seen", rsp_valid, 1);
        res = rsp_result;
        to  = rsp_timeout;
        r0  = rsp_result;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            check("bp_result_stable", rsp_result, r0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_no_start", add_start, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [RES_W-1:0] res;
        logic [RES_W-1:0] ex;
        logic             to;
        int               cyc;
        int               st;
        int               n0;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_sub   = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        adder_lat = 2;
        ad_never  = 1'b0;
        late_kick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_add_start", add_start, 0);
        check("rst_add_in_a", add_in_a, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // T1: 1+1
        issue(513'h1, 513'h1, 1'b0, 3);
        collect(0, res, to, cyc, st);
        check("t1_result", res, 514'h2);
        check("t1_timeout", to, 0);
        check("t1_latency", cyc, 5);
        check("t1_start_pulses", st, 1);

        // T2: 1-1, subtract held after the op
        issue(513'h1, 513'h1, 1'b1, 2);
        collect(0, res, to, cyc, st);
        check("t2_result", res, 514'h0);
        check("t2_latency", cyc, 4);
        @(negedge clk);
        check("t2_sub_held", add_subtract, 1);
        @(posedge clk);
        #1;

        // Borrow wrap and carry-out pass through bit-exact; minimum adder latency
        issue(513'h0, 513'h1, 1'b1, 1);
        collect(0, res, to, cyc, st);
        ex = '1;
        check("borrow_wrap", res, ex);
        check("min_latency", cyc, 3);
        issue('1, '1, 1'b0, 2);
        collect(0, res, to, cyc, st);
        ex    = '1;
        ex[0] = 1'b0;
        check("carry_out", res, ex);

        // T3: five cycles of backpressure
        issue(513'h10, 513'h20, 1'b0, 2);
        collect(5, res, to, cyc, st);
        check("t3_result", res, 514'h30);
        @(negedge clk);
        check("t3_cmd_ready_back", cmd_ready, 1);
        check("t3_rsp_valid_low", rsp_valid, 0);
        @(posedge clk);
        #1;

        // T4: adder still holds done from the previous op
        issue(513'h7, 513'h5, 1'b0, 2);
        collect(0, res, to, cyc, st);
        check("t4_first", res, 514'hC);
        issue(513'h9, 513'h4, 1'b1, 3);
        collect(0, res, to, cyc, st);
        check("t4_new_result", res, 514'h5);
        check("t4_latency", cyc, 5);

        // T5: reset in WAIT
        issue(513'h3, 513'h4, 1'b1, 10);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t5_in_reset_rsp_valid", rsp_valid, 0);
        check("t5_in_reset_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_add_start", add_start, 0);
        check("t5_add_subtract", add_subtract, 0);
        check("t5_add_in_a", add_in_a, 0);
        check("t5_add_in_b", add_in_b, 0);
        check("t5_rsp_result", rsp_result, 0);
        @(posedge clk);
        #1;
        issue(513'h1, 513'h1, 1'b0, 2);
        collect(0, res, to, cyc, st);
        check("t5_after_reset", res, 514'h2);

`ifdef MP_ADDER_DRV_TIMEOUT_EN
        // T6: adder never answers
        ad_never = 1'b1;
        issue(513'h5, 513'h6, 1'b0, 2);
        collect(0, res, to, cyc, st);
        ad_never = 1'b0;
        check("t6_cycles_after_start", cyc - 1, 17);
        check("t6_timeout", to, 1);
        check("t6_result", res, 514'h0);
        late_kick = 1'b1;
        @(posedge clk);
        #1;
        late_kick = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_late_done_rsp_valid", rsp_valid, 0);
            check("t6_late_done_cmd_ready", cmd_ready, 1);
        end
        @(posedge clk);
        #1;
`endif

        // Randomised traffic; the per-cycle compare does the checking
        n0 = n_rsp;
        for (int c = 0; c < 600; c++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_a     = rnd_op();
            cmd_b     = rnd_op();
            cmd_sub   = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 2) != 0);
            adder_lat = $urandom_range(1, 6);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rand_progress", (n_rsp - n0) > 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
